// File: rtl/sprite_rom_arbiter_pkg.sv
// Shared constants and types for the sprite ROM arbiter slice.
package sprite_pkg;

  localparam int SPRITE_ADDR_W  = 19;
  localparam int SPRITE_DATA_W  = 4;
  localparam int SPRITE_DIM     = 80;
  localparam int SPRITE_NUM_REQ = 4;

  typedef logic [$clog2(SPRITE_NUM_REQ)-1:0] req_id_t;
  typedef logic [SPRITE_DATA_W-1:0]          palette_idx_t;

endpackage

// File: rtl/sprite_rom_arbiter_if.sv
// Requester-side bundle: level requests with packed addresses, grants and the return path.
interface sprite_rom_arbiter_if #(
  parameter int NUM_REQ = sprite_pkg::SPRITE_NUM_REQ,
  parameter int ADDR_W  = sprite_pkg::SPRITE_ADDR_W,
  parameter int DATA_W  = sprite_pkg::SPRITE_DATA_W
) ();

  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ-1:0]        gnt;
  logic [DATA_W-1:0]         rdata;
  logic [NUM_REQ-1:0]        rvalid;

  modport master (output req, req_addr, input gnt, rdata, rvalid);
  modport slave  (input req, req_addr, output gnt, rdata, rvalid);

endinterface

// File: rtl/sprite_rom_arbiter_rr_arbiter.sv
// Combinational round-robin picker: rotate requests so ptr sits at bit 0, take the lowest set bit.
module rr_arbiter
  import sprite_pkg::*;
#(
  parameter int N = SPRITE_NUM_REQ
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] gnt_id
);

  localparam int ID_W = $clog2(N);

  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  logic           found;
  int             off;
  int             sum;

  always_comb begin
    dbl   = {req, req} >> ptr;
    rot   = dbl[N-1:0];
    found = 1'b0;
    off   = 0;
    for (int i = 0; i < N; i++) begin
      if (!found && rot[i]) begin
        found = 1'b1;
        off   = i;
      end
    end
    // Undo the rotation to recover the absolute requester index.
    sum = int'(ptr) + off;
    if (sum >= N) sum = sum - N;
    gnt_id      = ID_W'(sum);
    gnt         = '0;
    gnt[gnt_id] = found;
  end

endmodule

// File: rtl/sprite_rom_arbiter.sv
// Shares one synchronous sprite ROM among NUM_REQ requesters; results return two cycles after grant.
module sprite_rom_arbiter
  import sprite_pkg::*;
#(
  parameter int NUM_REQ = SPRITE_NUM_REQ,
  parameter int ADDR_W  = SPRITE_ADDR_W,
  parameter int DATA_W  = SPRITE_DATA_W
) (
  input  logic                vga_clk,
  input  logic                reset_n,
  sprite_rom_arbiter_if.slave bus,
  output logic [ADDR_W-1:0]   rom_addr,
  input  logic [DATA_W-1:0]   rom_q,
  output logic                busy
);

  localparam int ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0] arb_gnt;
  logic [NUM_REQ-1:0] gnt;
  logic [ID_W-1:0]    gnt_id;
  logic               any_gnt;

  logic [ID_W-1:0]    ptr_q, ptr_d;
  logic [ADDR_W-1:0]  rom_addr_q, rom_addr_d;
  logic               s1_vld_q, s1_vld_d;
  logic [ID_W-1:0]    s1_id_q, s1_id_d;
  logic [NUM_REQ-1:0] rvalid_q, rvalid_d;
  logic [DATA_W-1:0]  rdata_q, rdata_d;

  rr_arbiter #(.N(NUM_REQ)) u_rr_arbiter (
    .req    (bus.req),
    .ptr    (ptr_q),
    .gnt    (arb_gnt),
    .gnt_id (gnt_id)
  );

  always_comb begin
    gnt        = reset_n ? arb_gnt : '0;
    any_gnt    = |gnt;
    ptr_d      = ptr_q;
    rom_addr_d = rom_addr_q;
    if (any_gnt) begin
      rom_addr_d = bus.req_addr[int'(gnt_id)*ADDR_W +: ADDR_W];
      ptr_d      = (gnt_id == ID_W'(NUM_REQ-1)) ? '0 : gnt_id + ID_W'(1);
    end
    s1_vld_d          = any_gnt;
    s1_id_d           = gnt_id;
    rvalid_d          = '0;
    rvalid_d[s1_id_q] = s1_vld_q;
    rdata_d           = rom_q;
  end

  always_ff @(posedge vga_clk) begin
    if (!reset_n) begin
      ptr_q      <= '0;
      rom_addr_q <= '0;
      s1_vld_q   <= 1'b0;
      s1_id_q    <= '0;
      rvalid_q   <= '0;
      rdata_q    <= '0;
    end else begin
      ptr_q      <= ptr_d;
      rom_addr_q <= rom_addr_d;
      s1_vld_q   <= s1_vld_d;
      s1_id_q    <= s1_id_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
    end
  end

  // Idle cycles replay the last granted address so the ROM input does not toggle.
  assign rom_addr   = rom_addr_d;
  assign bus.gnt    = gnt;
  assign bus.rvalid = rvalid_q;
  assign bus.rdata  = rdata_q;
  assign busy       = s1_vld_q | (|rvalid_q);

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Directed and randomized bench for sprite_rom_arbiter with a grant-order model and return scoreboard.
module tb_sprite_rom_arbiter;
  import sprite_pkg::*;

  localparam int NUM_REQ = SPRITE_NUM_REQ;
  localparam int ADDR_W  = SPRITE_ADDR_W;
  localparam int DATA_W  = SPRITE_DATA_W;

  typedef struct {
    int                due;
    int                id;
    logic [DATA_W-1:0] data;
  } sb_t;

  logic              vga_clk = 1'b0;
  logic              reset_n;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_q;
  logic              busy;

  sprite_rom_arbiter_if #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  sprite_rom_arbiter #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .vga_clk  (vga_clk),
    .reset_n  (reset_n),
    .bus      (bus),
    .rom_addr (rom_addr),
    .rom_q    (rom_q),
    .busy     (busy)
  );

  always #5 vga_clk = ~vga_clk;

  // Synchronous ROM with easily predicted contents.
  always @(posedge vga_clk) rom_q <= rom_addr[3:0] ^ rom_addr[7:4];

  int                 total = 0;
  int                 bad   = 0;
  int                 cyc   = 0;
  int                 m_ptr = 0;
  logic [ADDR_W-1:0]  m_last_addr = '0;
  logic [NUM_REQ-1:0] m_last_gnt  = '0;
  logic [NUM_REQ-1:0] req_drv     = '0;
  logic [ADDR_W-1:0]  addr_drv [NUM_REQ];
  int                 wait_cnt [NUM_REQ];
  sb_t                sb [$];

  function automatic logic [DATA_W-1:0] romModel(input logic [ADDR_W-1:0] a);
    return a[3:0] ^ a[7:4];
  endfunction

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [NUM_REQ-1:0] r);
    req_drv = r;
    bus.req = r;
    for (int i = 0; i < NUM_REQ; i++) bus.req_addr[i*ADDR_W +: ADDR_W] = addr_drv[i];
  endtask

  task automatic checkOutput();
    logic [NUM_REQ-1:0] exp_gnt;
    logic [NUM_REQ-1:0] exp_rv;
    logic [ADDR_W-1:0]  exp_addr;
    int                 exp_id;
    bit                 found;
    bit                 exp_busy;
    sb_t                e;
    cyc++;
    exp_busy = 1'b0;
    foreach (sb[k]) if (sb[k].due == cyc || sb[k].due == cyc + 1) exp_busy = 1'b1;
    exp_gnt = '0;
    exp_id  = 0;
    found   = 1'b0;
    if (reset_n) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        automatic int idx = (m_ptr + k) % NUM_REQ;
        if (!found && req_drv[idx]) begin
          found  = 1'b1;
          exp_id = idx;
        end
      end
    end
    if (found) exp_gnt[exp_id] = 1'b1;
    exp_addr = found ? addr_drv[exp_id] : m_last_addr;
    checkVal("gnt", 32'(bus.gnt), 32'(exp_gnt));
    checkVal("rom_addr", 32'(rom_addr), 32'(exp_addr));
    checkVal("busy", 32'(busy), 32'(exp_busy));
    for (int i = 0; i < NUM_REQ; i++) begin
      if (reset_n && req_drv[i]) begin
        if (exp_gnt[i]) begin
          total++;
          assert (wait_cnt[i] <= NUM_REQ - 1) else begin
            bad++;
            $error("[TB] FAIL wait req=%0d observed=%0d expected<=%0d", i, wait_cnt[i], NUM_REQ - 1);
          end
          wait_cnt[i] = 0;
        end else begin
          wait_cnt[i]++;
        end
      end else begin
        wait_cnt[i] = 0;
      end
    end
    if (found) begin
      sb.push_back('{cyc + 2, exp_id, romModel(addr_drv[exp_id])});
      m_ptr       = (exp_id + 1) % NUM_REQ;
      m_last_addr = addr_drv[exp_id];
    end
    m_last_gnt = exp_gnt;
    exp_rv = '0;
    if (sb.size() > 0 && sb[0].due == cyc) begin
      e = sb.pop_front();
      exp_rv[e.id] = 1'b1;
      checkVal("rdata", 32'(bus.rdata), 32'(e.data));
    end
    checkVal("rvalid", 32'(bus.rvalid), 32'(exp_rv));
    if (!reset_n) begin
      sb.delete();
      m_ptr       = 0;
      m_last_addr = '0;
    end
  endtask

  task automatic tick();
    @(negedge vga_clk);
    checkOutput();
    @(posedge vga_clk);
    #1;
  endtask

  initial begin
    logic [NUM_REQ-1:0] nreq;
    for (int i = 0; i < NUM_REQ; i++) begin
      addr_drv[i] = ADDR_W'(19'h12300 + i * 19'h11);
      wait_cnt[i] = 0;
    end

    // Reset held with all requests up, then round-robin from ptr=0.
    reset_n = 1'b0;
    applyStimulus(4'b1111);
    repeat (3) tick();
    reset_n = 1'b1;
    repeat (8) tick();
    applyStimulus(4'b0000);
    repeat (3) tick();

    // Sole requester gets full throughput.
    addr_drv[2] = 19'h00123;
    applyStimulus(4'b0100);
    repeat (5) tick();
    applyStimulus(4'b0000);
    repeat (3) tick();

    // Pointer retains its value across idle cycles.
    addr_drv[0] = 19'h000a5;
    addr_drv[1] = 19'h0003c;
    addr_drv[3] = 19'h7ff0f;
    applyStimulus(4'b0100);
    tick();
    applyStimulus(4'b0000);
    repeat (3) tick();
    applyStimulus(4'b1011);
    tick();
    applyStimulus(4'b0011);
    tick();
    applyStimulus(4'b0010);
    tick();
    applyStimulus(4'b0000);
    repeat (3) tick();

    // Reset lands while a read is in flight.
    applyStimulus(4'b1111);
    tick();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    applyStimulus(4'b0000);
    repeat (3) tick();

    // Randomized fairness: requester 0 always on, others come and go after being served.
    for (int c = 0; c < 1000; c++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (i == 0) begin
          if (m_last_gnt[0]) addr_drv[0] = ADDR_W'($urandom_range(0, (1 << ADDR_W) - 1));
          nreq[0] = 1'b1;
        end else if (!req_drv[i] || m_last_gnt[i]) begin
          nreq[i]     = 1'($urandom_range(0, 1));
          addr_drv[i] = ADDR_W'($urandom_range(0, (1 << ADDR_W) - 1));
        end else begin
          nreq[i] = 1'b1;
        end
      end
      applyStimulus(nreq);
      tick();
    end
    applyStimulus(4'b0000);
    repeat (4) tick();
    checkVal("sb_empty", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sprite_rom_arbiter.md
# sprite_rom_arbiter

Shares one synchronous sprite ROM (jet_rom-style, 19-bit address, 4-bit palette index) among up to four pixel requesters: player jets, bullets and HUD overlays. Round-robin arbitration grants one read per clock. Each read is tracked through a two-stage pipeline, and the palette index is returned to the requester that issued it. The block sits between the per-object sprite address generators and the single ROM instance ahead of the palette lookup, all in the VGA pixel clock domain.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- ADDR_W, 19, ROM address width
- DATA_W, 4, ROM word width (palette index)
- vga_clk  in  1  pixel clock; all logic on rising edge
- reset_n  in  1  synchronous, active-low reset
- req  in  NUM_REQ  per-requester read request, level; held until granted
- req_addr  in  NUM_REQ*ADDR_W  packed addresses, requester i at bits [i*ADDR_W +: ADDR_W]; stable while req[i]=1
- gnt  out  NUM_REQ  one-hot grant, combinational, at most one bit set
- rom_addr  out  ADDR_W  address to ROM, combinational mux of granted req_addr
- rom_q  in  DATA_W  ROM output; ROM registers the address on rising vga_clk
- rdata  out  DATA_W  returned palette index, registered
- rvalid  out  NUM_REQ  one-hot return strobe, registered
- busy  out  1  high when any read is in flight (stage 1 or stage 2 valid)

## Operation
- Arbitration: rotating priority pointer ptr (0..NUM_REQ-1). Search order is ptr, ptr+1, … modulo NUM_REQ. First requester found with req=1 gets gnt.
- Pointer update: on a cycle with any grant to requester k, ptr <= (k+1) mod NUM_REQ. With no grant, ptr holds.
- Grant means the read is accepted. The requester drops req or presents its next address in the following cycle.
- Back-to-back: a sole active requester is granted every cycle (full throughput).
- Fairness: a continuously requesting requester waits at most NUM_REQ-1 cycles for gnt.
- rom_addr = req_addr of granted requester. With no grant, rom_addr holds its last granted value, from a register updated on grant; reset value 0. This gives no spurious ROM toggling.
- Stage 1 (cycle N+1): tag register s1_id, s1_vld captures granted index.
- Stage 2 (cycle N+2): rdata <= rom_q, rvalid <= onehot(s1_id) & {NUM_REQ{s1_vld}}.
- Out-of-range requesters do not exist; NUM_REQ bits are all valid.
- No backpressure on the return path. Requesters must accept rdata whenever rvalid is asserted.

## Timing
- Grant in cycle N → rvalid/rdata in cycle N+2 (latency 2), one result per cycle sustained.
- gnt depends on req and ptr only. gnt is forced to 0 while reset_n=0.
- Reset values: ptr=0, s1_vld=0, rvalid=0, rdata=0, rom_addr register=0, busy=0.
- Reset mid-operation: in-flight stage-1/stage-2 reads are discarded. No rvalid appears in the two cycles after reset_n rises unless new grants occur.
- req asserted in the same cycle reset_n rises: eligible for grant that cycle.
- Simultaneous requests from all requesters with ptr=0: grant order 0,1,2,3,0,…
- req[i] dropped without grant: no effect. Requesters must not do this, but the arbiter tolerates it.

## Structure
- Package sprite_pkg:
  - constants SPRITE_ADDR_W=19, SPRITE_DATA_W=4, SPRITE_DIM=80, SPRITE_NUM_REQ=4
  - typedef req_id_t (logic [$clog2(SPRITE_NUM_REQ)-1:0])
  - typedef palette_idx_t
- Sub-module rr_arbiter: parameter N, inputs req and ptr, outputs one-hot gnt and encoded gnt_id.
  - Implemented with the double-width rotate-and-priority-encode.
  - Purely combinational; ptr register stays in sprite_rom_arbiter.
- Model the ROM in the bench as a synchronous array with q = addr[3:0] ^ addr[7:4] for checkable data.

## Test plan
- Reset: hold reset_n=0 for 3 cycles with req=4'b1111 → gnt=0, rvalid=0, busy=0. Release → gnt=0001 in the first cycle.
- Single requester: req=0100, addr=0x00123 every cycle for 5 cycles → gnt[2] every cycle; rvalid=0100 from cycle 2 onward, with rdata = model(0x00123).
- Round-robin: req=1111 continuously from reset → gnt sequence 0001,0010,0100,1000,0001. Each rvalid is one-hot and trails its gnt by exactly 2 cycles, with correct rdata per address.
- Fairness: req[0] held, req[1..3] toggled randomly for 1000 cycles → every requester's req-to-gnt wait is ≤3 cycles. The scoreboard matches every grant to exactly one rvalid.
- Pointer hold: grant to 2, then 3 idle cycles, then req=1011 → gnt=1000 (ptr=3 retained), then 0001, then 0010.
- Reset mid-flight: grants in cycles 10 and 11, reset_n=0 in cycle 11 → no rvalid in cycles 12–13, busy=0 after reset.
